// File: rtl/cu_command_tag_responder.sv
// Tag table between the CU command buffers and the PSL command/response ports.
// Allocates the lowest free tag per command, issues under credits, replays PAGED tags, completes others to the CU.
module cu_command_tag_responder #(
    parameter int NUM_TAGS    = 32,
    parameter int CMD_CREDITS = 16
) (
    input  logic        clock,
    input  logic        rstn,
    input  logic        enabled_in,
    input  logic        cmd_valid_in,
    output logic        cmd_ready_out,
    input  logic [1:0]  cmd_type_in,
    input  logic [63:0] cmd_address_in,
    input  logic [11:0] cmd_size_in,
    input  logic [7:0]  cmd_cu_id_in,
    output logic        psl_cmd_valid_out,
    output logic [7:0]  psl_cmd_tag_out,
    output logic [12:0] psl_cmd_code_out,
    output logic [63:0] psl_cmd_address_out,
    output logic [11:0] psl_cmd_size_out,
    input  logic        psl_rsp_valid_in,
    input  logic [7:0]  psl_rsp_tag_in,
    input  logic [7:0]  psl_rsp_code_in,
    output logic        rsp_valid_out,
    output logic [1:0]  rsp_type_out,
    output logic [63:0] rsp_address_out,
    output logic [7:0]  rsp_cu_id_out,
    output logic [7:0]  rsp_tag_out,
    output logic        rsp_error_out,
    output logic [7:0]  rsp_code_out,
    output logic [8:0]  outstanding_out,
    output logic [7:0]  credits_out,
    output logic [31:0] error_count_out,
    output logic        spurious_out
);
    localparam int TW = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
    localparam int CW = $clog2(NUM_TAGS + 1);

    logic [NUM_TAGS-1:0] alloc_q;
    logic [1:0]          tbl_type [NUM_TAGS];
    logic [63:0]         tbl_addr [NUM_TAGS];
    logic [11:0]         tbl_size [NUM_TAGS];
    logic [7:0]          tbl_cu   [NUM_TAGS];
    logic [TW-1:0]       rq_mem   [NUM_TAGS];
    logic [TW-1:0]       rq_rd, rq_wr;
    logic [CW-1:0]       rq_cnt;

    logic [TW-1:0]       free_tag, iss_tag, rsp_idx;
    logic                free_any, have_credit, rq_empty, accept, replay, issue;
    logic                rsp_in_range, rsp_hit, is_done, is_paged, push, free_now;
    logic [1:0]          iss_type;
    logic [63:0]         iss_addr;
    logic [11:0]         iss_size;
    logic [NUM_TAGS-1:0] acc_mask, free_mask;
    logic [8:0]          cred_sum;
    logic [7:0]          credits_nx;

    function automatic logic [TW-1:0] ptr_inc(input logic [TW-1:0] p);
        return (int'(p) == NUM_TAGS - 1) ? '0 : p + 1'b1;
    endfunction

    // Lowest free tag wins: scan downward so the last hit is the smallest index.
    always_comb begin
        free_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--)
            if (!alloc_q[i]) free_tag = TW'(i);
    end

    always_comb begin
        outstanding_out = '0;
        for (int i = 0; i < NUM_TAGS; i++)
            outstanding_out = outstanding_out + 9'(alloc_q[i]);
    end

    assign free_any      = |(~alloc_q);
    assign have_credit   = (credits_out != 8'd0);
    assign rq_empty      = (rq_cnt == '0);
    assign cmd_ready_out = enabled_in & free_any & have_credit & rq_empty;
    assign accept        = cmd_valid_in & cmd_ready_out;
    // Ready already requires an empty replay FIFO, so replay and accept never collide.
    assign replay        = ~rq_empty & have_credit;
    assign issue         = accept | replay;

    assign rsp_in_range  = int'(psl_rsp_tag_in) < NUM_TAGS;
    assign rsp_idx       = psl_rsp_tag_in[TW-1:0];
    assign rsp_hit       = psl_rsp_valid_in & rsp_in_range & alloc_q[rsp_idx];
    assign is_done       = (psl_rsp_code_in == 8'h00);
    assign is_paged      = (psl_rsp_code_in == 8'h0A);
    assign push          = rsp_hit & is_paged;
    assign free_now      = rsp_hit & ~is_paged;

    assign acc_mask  = accept   ? (NUM_TAGS'(1) << free_tag) : '0;
    assign free_mask = free_now ? (NUM_TAGS'(1) << rsp_idx)  : '0;

    always_comb begin
        iss_tag  = replay ? rq_mem[rq_rd] : free_tag;
        iss_type = replay ? tbl_type[iss_tag] : cmd_type_in;
        iss_addr = replay ? tbl_addr[iss_tag] : cmd_address_in;
        iss_size = replay ? tbl_size[iss_tag] : cmd_size_in;
    end

    // Every hit response returns its credit; returns beyond the reset level are dropped.
    assign cred_sum   = {1'b0, credits_out} - {8'b0, issue} + {8'b0, rsp_hit};
    assign credits_nx = (cred_sum > 9'(CMD_CREDITS)) ? 8'(CMD_CREDITS) : cred_sum[7:0];

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            alloc_q             <= '0;
            credits_out         <= 8'(CMD_CREDITS);
            rq_rd               <= '0;
            rq_wr               <= '0;
            rq_cnt              <= '0;
            psl_cmd_valid_out   <= 1'b0;
            psl_cmd_tag_out     <= '0;
            psl_cmd_code_out    <= '0;
            psl_cmd_address_out <= '0;
            psl_cmd_size_out    <= '0;
            rsp_valid_out       <= 1'b0;
            rsp_type_out        <= '0;
            rsp_address_out     <= '0;
            rsp_cu_id_out       <= '0;
            rsp_tag_out         <= '0;
            rsp_error_out       <= 1'b0;
            rsp_code_out        <= '0;
            error_count_out     <= '0;
            spurious_out        <= 1'b0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                tbl_type[i] <= '0;
                tbl_addr[i] <= '0;
                tbl_size[i] <= '0;
                tbl_cu[i]   <= '0;
                rq_mem[i]   <= '0;
            end
        end else begin
            alloc_q     <= (alloc_q | acc_mask) & ~free_mask;
            credits_out <= credits_nx;

            psl_cmd_valid_out <= issue;
            if (issue) begin
                psl_cmd_tag_out     <= 8'(iss_tag);
                // Unknown types go out as reads; the PSL error response completes them.
                psl_cmd_code_out    <= (iss_type == 2'd2) ? 13'h0D00 : 13'h0A00;
                psl_cmd_address_out <= iss_addr;
                psl_cmd_size_out    <= iss_size;
            end

            if (accept) begin
                tbl_type[free_tag] <= cmd_type_in;
                tbl_addr[free_tag] <= cmd_address_in;
                tbl_size[free_tag] <= cmd_size_in;
                tbl_cu[free_tag]   <= cmd_cu_id_in;
            end

            if (push) begin
                rq_mem[rq_wr] <= rsp_idx;
                rq_wr         <= ptr_inc(rq_wr);
            end
            if (replay) rq_rd <= ptr_inc(rq_rd);
            rq_cnt <= rq_cnt + CW'(push) - CW'(replay);

            rsp_valid_out <= free_now;
            if (free_now) begin
                rsp_type_out    <= tbl_type[rsp_idx];
                rsp_address_out <= tbl_addr[rsp_idx];
                rsp_cu_id_out   <= tbl_cu[rsp_idx];
                rsp_tag_out     <= psl_rsp_tag_in;
                rsp_error_out   <= ~is_done;
                rsp_code_out    <= psl_rsp_code_in;
            end

            if (free_now && !is_done && !(&error_count_out))
                error_count_out <= error_count_out + 32'd1;
            if (psl_rsp_valid_in && !rsp_hit)
                spurious_out <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cu_command_tag_responder.sv
// Scoreboard bench: a tag-set/queue model predicts PSL issues and CU responses; a monitor compares them.
module tb_cu_command_tag_responder;
    localparam int NT = 32;
    localparam int NC = 16;

    logic        clock = 1'b0, rstn = 1'b0;
    logic        enabled_in = 0, cmd_valid_in = 0, cmd_ready_out;
    logic [1:0]  cmd_type_in = 0;
    logic [63:0] cmd_address_in = 0;
    logic [11:0] cmd_size_in = 0;
    logic [7:0]  cmd_cu_id_in = 0;
    logic        psl_cmd_valid_out;
    logic [7:0]  psl_cmd_tag_out;
    logic [12:0] psl_cmd_code_out;
    logic [63:0] psl_cmd_address_out;
    logic [11:0] psl_cmd_size_out;
    logic        psl_rsp_valid_in = 0;
    logic [7:0]  psl_rsp_tag_in = 0, psl_rsp_code_in = 0;
    logic        rsp_valid_out;
    logic [1:0]  rsp_type_out;
    logic [63:0] rsp_address_out;
    logic [7:0]  rsp_cu_id_out, rsp_tag_out, rsp_code_out;
    logic        rsp_error_out;
    logic [8:0]  outstanding_out;
    logic [7:0]  credits_out;
    logic [31:0] error_count_out;
    logic        spurious_out;

    cu_command_tag_responder #(.NUM_TAGS(NT), .CMD_CREDITS(NC)) dut (
        .clock(clock), .rstn(rstn), .enabled_in(enabled_in),
        .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
        .cmd_type_in(cmd_type_in), .cmd_address_in(cmd_address_in),
        .cmd_size_in(cmd_size_in), .cmd_cu_id_in(cmd_cu_id_in),
        .psl_cmd_valid_out(psl_cmd_valid_out), .psl_cmd_tag_out(psl_cmd_tag_out),
        .psl_cmd_code_out(psl_cmd_code_out), .psl_cmd_address_out(psl_cmd_address_out),
        .psl_cmd_size_out(psl_cmd_size_out), .psl_rsp_valid_in(psl_rsp_valid_in),
        .psl_rsp_tag_in(psl_rsp_tag_in), .psl_rsp_code_in(psl_rsp_code_in),
        .rsp_valid_out(rsp_valid_out), .rsp_type_out(rsp_type_out),
        .rsp_address_out(rsp_address_out), .rsp_cu_id_out(rsp_cu_id_out),
        .rsp_tag_out(rsp_tag_out), .rsp_error_out(rsp_error_out), .rsp_code_out(rsp_code_out),
        .outstanding_out(outstanding_out), .credits_out(credits_out),
        .error_count_out(error_count_out), .spurious_out(spurious_out)
    );

    always #5 clock = ~clock;

    typedef struct { int cyc; int tag; logic [12:0] code; logic [63:0] addr; logic [11:0] size; } psl_e;
    typedef struct { int cyc; logic [1:0] ty; logic [63:0] addr; logic [7:0] cu; int tag; logic err; logic [7:0] code; } rsp_e;

    psl_e pq[$];
    rsp_e sq[$];
    psl_e pe;
    rsp_e se;

    // Reference model: a set of allocated tags with their stored commands, a replay list and credit count.
    bit          m_alloc [NT];
    logic [1:0]  m_type  [NT];
    logic [63:0] m_addr  [NT];
    logic [11:0] m_size  [NT];
    logic [7:0]  m_cu    [NT];
    int          rq[$];
    int          inflight[$];
    int          m_cred;
    int unsigned m_err;
    bit          m_spur;

    int checks = 0, errors = 0, cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [12:0] code_of(input logic [1:0] t);
        return (t == 2'd2) ? 13'h0D00 : 13'h0A00;
    endfunction

    function automatic int outstanding_model();
        int n = 0;
        for (int i = 0; i < NT; i++) n += m_alloc[i];
        return n;
    endfunction

    always @(posedge clock) begin
        cyc++;
        #2;
        if (rstn) begin
            if (psl_cmd_valid_out) begin
                if (pq.size() == 0) chk("psl_unexpected", 1, 0);
                else begin
                    pe = pq.pop_front();
                    chk("psl_cycle", cyc, pe.cyc);
                    chk("psl_tag", psl_cmd_tag_out, pe.tag);
                    chk("psl_code", psl_cmd_code_out, pe.code);
                    chk("psl_addr", psl_cmd_address_out, pe.addr);
                    chk("psl_size", psl_cmd_size_out, pe.size);
                end
            end else if (pq.size() > 0 && pq[0].cyc <= cyc) begin
                chk("psl_missing", 0, 1);
                void'(pq.pop_front());
            end
            if (rsp_valid_out) begin
                if (sq.size() == 0) chk("rsp_unexpected", 1, 0);
                else begin
                    se = sq.pop_front();
                    chk("rsp_cycle", cyc, se.cyc);
                    chk("rsp_type", rsp_type_out, se.ty);
                    chk("rsp_addr", rsp_address_out, se.addr);
                    chk("rsp_cu", rsp_cu_id_out, se.cu);
                    chk("rsp_tag", rsp_tag_out, se.tag);
                    chk("rsp_err", rsp_error_out, se.err);
                    if (se.err) chk("rsp_code", rsp_code_out, se.code);
                end
            end else if (sq.size() > 0 && sq[0].cyc <= cyc) begin
                chk("rsp_missing", 0, 1);
                void'(sq.pop_front());
            end
            chk("credits", credits_out, m_cred);
            chk("outstanding", outstanding_out, outstanding_model());
            chk("error_count", error_count_out, m_err);
            chk("spurious", spurious_out, m_spur);
        end
    end

    task automatic model_clear();
        for (int i = 0; i < NT; i++) m_alloc[i] = 0;
        rq.delete(); inflight.delete(); pq.delete(); sq.delete();
        m_cred = NC; m_err = 0; m_spur = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        rstn = 0;
        enabled_in = 0; cmd_valid_in = 0; psl_rsp_valid_in = 0;
        model_clear();
        #1;
        chk("rst_psl_valid", psl_cmd_valid_out, 0);
        chk("rst_rsp_valid", rsp_valid_out, 0);
        chk("rst_outstanding", outstanding_out, 0);
        chk("rst_credits", credits_out, NC);
        chk("rst_err_count", error_count_out, 0);
        chk("rst_spurious", spurious_out, 0);
        chk("rst_ready", cmd_ready_out, 0);
        @(negedge clock);
        rstn = 1;
    endtask

    // Drive one cycle of inputs, check ready, and advance the model across the coming edge.
    task automatic step(input bit en, input bit v, input logic [1:0] ty, input logic [63:0] a,
                        input logic [11:0] sz, input logic [7:0] cu,
                        input bit rv, input logic [7:0] rt, input logic [7:0] rc);
        bit rdy, hit, issued, ret;
        int ft, t;
        @(negedge clock);
        enabled_in = en; cmd_valid_in = v; cmd_type_in = ty; cmd_address_in = a;
        cmd_size_in = sz; cmd_cu_id_in = cu;
        psl_rsp_valid_in = rv; psl_rsp_tag_in = rt; psl_rsp_code_in = rc;
        #1;
        ft = -1;
        for (int i = NT - 1; i >= 0; i--) if (!m_alloc[i]) ft = i;
        rdy = en && ft >= 0 && m_cred > 0 && rq.size() == 0;
        chk("ready", cmd_ready_out, rdy);
        hit = rv && rt < NT && m_alloc[rt];
        issued = 0; ret = 0;
        if (rq.size() > 0 && m_cred > 0) begin
            t = rq.pop_front();
            pq.push_back('{cyc + 1, t, code_of(m_type[t]), m_addr[t], m_size[t]});
            inflight.push_back(t);
            issued = 1;
        end else if (v && rdy) begin
            t = ft;
            m_alloc[t] = 1; m_type[t] = ty; m_addr[t] = a; m_size[t] = sz; m_cu[t] = cu;
            pq.push_back('{cyc + 1, t, code_of(ty), a, sz});
            inflight.push_back(t);
            issued = 1;
        end
        if (rv) begin
            if (hit) begin
                for (int k = 0; k < inflight.size(); k++)
                    if (inflight[k] == int'(rt)) begin inflight.delete(k); break; end
                ret = 1;
                if (rc == 8'h0A) rq.push_back(int'(rt));
                else begin
                    sq.push_back('{cyc + 1, m_type[rt], m_addr[rt], m_cu[rt], int'(rt), rc != 0, rc});
                    m_alloc[rt] = 0;
                    if (rc != 0 && m_err != 32'hFFFF_FFFF) m_err++;
                end
            end else m_spur = 1;
        end
        m_cred = m_cred - int'(issued) + int'(ret);
        if (m_cred > NC) m_cred = NC;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic respond(input logic [7:0] t, input logic [7:0] c);
        step(1, 0, 0, 0, 0, 0, 1, t, c);
    endtask

    initial begin
        logic [7:0] rt, rc;
        bit rv;
        model_clear();
        do_reset();

        // Single read then DONE.
        step(1, 1, 2'd1, 64'h1000, 12'd64, 8'd3, 0, 0, 0);
        idle(1);
        chk("t1_credits_after_issue", credits_out, NC - 1);
        respond(8'd0, 8'h00);
        idle(2);
        chk("t1_credits_after_done", credits_out, NC);

        // Fill every credit with writes, then free tag 5 and reuse it.
        for (int i = 0; i < 17; i++)
            step(1, 1, 2'd2, 64'h2000 + 64'(i * 64), 12'd128, 8'(i), 0, 0, 0);
        chk("t2_ready_low", cmd_ready_out, 0);
        respond(8'd5, 8'h00);
        step(1, 1, 2'd2, 64'h9000, 12'd32, 8'd7, 0, 0, 0);
        idle(1);
        chk("t2_outstanding", outstanding_out, 16);

        // PAGED on tag 2 while a new command is held: replay goes first.
        step(1, 1, 2'd1, 64'hA000, 12'd8, 8'd9, 1, 8'd2, 8'h0A);
        for (int i = 0; i < 3; i++) step(1, 1, 2'd1, 64'hA000, 12'd8, 8'd9, 0, 0, 0);
        chk("t3_outstanding", outstanding_out, 16);
        respond(8'd2, 8'h00);
        respond(8'd1, 8'h03);
        idle(1);
        chk("t4_error_count", error_count_out, 1);
        while (inflight.size() > 0) respond(8'(inflight[0]), 8'h00);
        idle(2);

        // Response to a tag that was never issued.
        respond(8'd9, 8'h00);
        idle(2);
        chk("t5_spurious", spurious_out, 1);
        chk("t5_credits", credits_out, NC);

        // Reset with work in flight.
        for (int i = 0; i < 8; i++) step(1, 1, 2'd1, 64'h4000 + 64'(i), 12'd4, 8'd1, 0, 0, 0);
        do_reset();
        step(1, 1, 2'd2, 64'h5000, 12'd16, 8'd2, 0, 0, 0);
        idle(2);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            rv = 0; rt = 0; rc = 0;
            if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
                rv = 1;
                rt = 8'(inflight[$urandom_range(0, inflight.size() - 1)]);
                case ($urandom_range(0, 19))
                    0, 1, 2: rc = 8'h0A;
                    3, 4:    rc = 8'($urandom_range(11, 255));
                    5:       rc = 8'($urandom_range(1, 9));
                    default: rc = 8'h00;
                endcase
            end else if ($urandom_range(0, 40) == 0) begin
                rt = 8'($urandom_range(0, 63));
                rv = !(rt < NT && m_alloc[rt]);
            end
            step($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0, 2'($urandom_range(1, 2)),
                 {$urandom, $urandom}, 12'($urandom), 8'($urandom), rv, rt, rc);
        end
        for (int n = 0; n < 200 && (inflight.size() > 0 || rq.size() > 0); n++)
            if (inflight.size() > 0) respond(8'(inflight[0]), 8'h00);
            else idle(1);
        idle(3);
        chk("psl_queue_drained", pq.size(), 0);
        chk("rsp_queue_drained", sq.size(), 0);
        chk("final_outstanding", outstanding_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
